// File: rtl/npc_pkg.sv
// Shared encoder/decoder definitions: extop format codes and RV32 major opcodes.
// The format codes must stay identical to the decoder's extop values.
package npc_pkg;

  typedef enum logic [3:0] {
    FMT_JALR   = 4'h0,
    FMT_LOAD   = 4'h1,
    FMT_ARITH  = 4'h2,
    FMT_CSR    = 4'h4,
    FMT_STORE  = 4'h5,
    FMT_BRANCH = 4'h6,
    FMT_JAL    = 4'h7,
    FMT_LUI    = 4'h8,
    FMT_AUIPC  = 4'h9,
    FMT_R      = 4'ha
  } ext_fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITH  = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // True when v[31:lsb] are all equal, i.e. v fits a signed field whose sign bit is at lsb.
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/npc_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides; DEPTH must be a power of 2.
// Handshake: a transfer happens on a posedge where valid && ready; ready never depends on valid.
module npc_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign wr_ready = (count != (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (push && rst_n) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap for free because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Field-level request -> RV32 instruction word, range-checked and queued in a FIFO.
// Handshake: in and out transfer on a posedge where valid && ready; in_ready depends on count only.
module inst_encoder
  import npc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CW-1:0]    count,
  output logic [CNT_W-1:0] err_cnt
);

  logic [31:0] enc;
  logic        ok;
  logic [31:0] word;
  logic        err;
  logic        accept;

  always_comb begin
    enc = '0;
    ok  = 1'b0;
    case (in_fmt)
      FMT_R: begin
        enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
        ok  = 1'b1;
      end
      FMT_JALR: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
        ok  = sext_ok(in_imm, 11);
      end
      FMT_LOAD: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        ok  = sext_ok(in_imm, 11);
      end
      FMT_ARITH: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ARITH};
        ok  = sext_ok(in_imm, 11);
      end
      FMT_STORE: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        ok  = sext_ok(in_imm, 11);
      end
      FMT_BRANCH: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11],
               OP_BRANCH};
        ok  = sext_ok(in_imm, 12) && !in_imm[0];
      end
      FMT_LUI: begin
        enc = {in_imm[31:12], in_rd, OP_LUI};
        ok  = (in_imm[11:0] == '0);
      end
      FMT_AUIPC: begin
        enc = {in_imm[31:12], in_rd, OP_AUIPC};
        ok  = (in_imm[11:0] == '0);
      end
      FMT_JAL: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        ok  = sext_ok(in_imm, 20) && !in_imm[0];
      end
      FMT_CSR: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_SYSTEM};
        ok  = (in_imm[31:12] == '0);
      end
      default: begin
        enc = '0;
        ok  = 1'b0;
      end
    endcase
  end

  // Failing requests still occupy a slot, carrying a zero word and the error flag.
  assign word   = ok ? enc : 32'h0;
  assign err    = !ok;
  assign accept = in_valid && in_ready;

  npc_sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({err, word}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  ({out_err, out_inst}),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table through a scoreboard, plus hand-written FIFO corner cases.
module tb_inst_encoder;

  typedef struct {
    logic [3:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_fmt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [2:0]  count;
  logic [7:0]  err_cnt;

  logic [32:0] exp_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[NV];

  inst_encoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .count     (count),
    .err_cnt   (err_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=0x%0h req=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] inst, input logic err);
    vec_t v;
    v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.inst = inst; v.err = err;
    return v;
  endfunction

  // scoreboard: compare the head whenever a pop will happen at the coming edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: act=0x%0h req=none", {out_err, out_inst});
      end else begin
        check("pop_data", {31'b0, out_err, out_inst}, {31'b0, exp_q.pop_front()});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // drivers
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    pop_cyc.delete();
  endtask

  task automatic send(input vec_t v);
    in_valid = 1'b1;
    in_fmt = v.fmt; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({v.err, v.inst});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: act=in_ready_low req=accept");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    int   exp_errs;
    vec_t v;

    vecs[0]  = mk(4'h2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd5,        32'h00500093, 1'b0);
    vecs[1]  = mk(4'h8, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,  32'h12345000, 32'h123452B7, 1'b0);
    vecs[2]  = mk(4'h7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd8,        32'h008000EF, 1'b0);
    vecs[3]  = mk(4'h6, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,  32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    vecs[4]  = mk(4'h2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h00000800, 32'h00000000, 1'b1);
    vecs[5]  = mk(4'h6, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,  32'd3,        32'h00000000, 1'b1);
    vecs[6]  = mk(4'h3, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0,  32'd0,        32'h00000000, 1'b1);
    vecs[7]  = mk(4'ha, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0);
    vecs[8]  = mk(4'h5, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,  32'd8,        32'h0020A423, 1'b0);
    vecs[9]  = mk(4'h1, 5'd3, 5'd1, 5'd0, 3'd2, 7'd0,  32'hFFFFFFFC, 32'hFFC0A183, 1'b0);
    vecs[10] = mk(4'h4, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0,  32'h00000300, 32'h300110F3, 1'b0);
    vecs[11] = mk(4'h4, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0,  32'h00001000, 32'h00000000, 1'b1);
    vecs[12] = mk(4'h8, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,  32'h12345001, 32'h00000000, 1'b1);
    vecs[13] = mk(4'h9, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,  32'h00001000, 32'h00001117, 1'b0);
    vecs[14] = mk(4'h0, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0,  32'd0,        32'h00008067, 1'b0);
    vecs[15] = mk(4'h7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h00100000, 32'h00000000, 1'b1);
    vecs[16] = mk(4'h2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFFF800, 32'h80000093, 1'b0);
    vecs[17] = mk(4'h2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h000007FF, 32'h7FF00093, 1'b0);

    // reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // single addi: visible one edge after acceptance
    send(vecs[0]);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_inst", 64'(out_inst), 64'h00500093);
    check("lat_out_err", 64'(out_err), 64'd0);
    check("lat_count", 64'(count), 64'd1);
    drain();

    // back-to-back lui/jal/beq, popped on consecutive cycles
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) send(vecs[i]);
    drain();
    check("b2b_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) check("b2b_spacing", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);

    // whole table with running error count
    do_reset();
    out_ready = 1'b1;
    exp_errs = 0;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      if (vecs[i].err) exp_errs++;
      check($sformatf("err_cnt_v%0d", i), 64'(err_cnt), 64'(exp_errs));
    end
    drain();

    // fill to full, hold a fifth request, release it with a single pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(vecs[7 + i]);
      check("fill_in_ready", 64'(in_ready), (i < 3) ? 64'd1 : 64'd0);
    end
    check("full_count", 64'(count), 64'd4);
    fork
      send(vecs[13]);
      begin
        repeat (3) begin
          @(negedge clk);
          check("held_in_ready", 64'(in_ready), 64'd0);
          check("held_count", 64'(count), 64'd4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    check("refill_count", 64'(count), 64'd4);
    drain();

    // steady push+pop at count 2; pointers wrap several times
    do_reset();
    send(vecs[1]);
    send(vecs[2]);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[(i * 5) % NV]);
      check("steady_count", 64'(count), 64'd2);
    end
    drain();

    // error counter saturation with random invalid formats
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      v = mk(4'h3, 5'($urandom_range(0, 31)), 5'd0, 5'd0, 3'd0, 7'd0, $urandom, 32'h0, 1'b1);
      v.fmt = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'($urandom_range(11, 15));
      send(v);
    end
    check("err_cnt_sat", 64'(err_cnt), 64'd255);
    drain();

    // mid-operation reset with a request pending
    do_reset();
    send(vecs[0]);
    send(vecs[4]);
    send(vecs[6]);
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_err_cnt", 64'(err_cnt), 64'd2);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_fmt = 4'h3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("mid_rst_dropped", 64'(count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
